// File: rtl/tlul_reg_bridge.sv
// tlul_reg_bridge: TL-UL device endpoint converting single-outstanding requests into a strobe/ready register bus.
`timescale 1ns/1ps
package tlul_pkg;
  localparam logic [2:0] PutFullData = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get = 3'h4;
  localparam logic [2:0] AccessAck = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;
  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;
  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
  // 7-bit interleaved inverted parity: bit i covers payload bits i, i+7, i+14, ...
  function automatic logic [6:0] intg7(input logic [63:0] v);
    logic [6:0] r;
    r = '0;
    for (int j = 0; j < 64; j++) r[j % 7] ^= v[j];
    return ~r;
  endfunction
endpackage

module tlul_reg_bridge
  import tlul_pkg::*;
#(
  parameter int AW = 8,
  parameter int TimeoutCycles = 255,
  parameter bit EnableCmdIntgChk = 1'b1,
  parameter bit EnableRspIntgGen = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output logic          reg_re_o,
  output logic          reg_we_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [31:0]   reg_wdata_o,
  output logic [3:0]    reg_be_o,
  input  logic [31:0]   reg_rdata_i,
  input  logic          reg_ready_i,
  input  logic          reg_err_i,
  output logic          intg_err_o
);
  localparam int CW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  typedef enum logic [1:0] {Idle, Access, Rsp} state_e;
  state_e state_q, state_d;
  logic get_q, get_d, err_q, err_d, intg_err_q, intg_err_d;
  logic [1:0] size_q, size_d;
  logic [7:0] src_q, src_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0] mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] lo;
  logic [3:0] full_mask;
  logic intg_bad, req_bad, timeout, unused_param;
  logic [2:0] d_op;
  logic [31:0] d_data;
  assign unused_param = ^tl_i.a_param;
  assign lo = tl_i.a_address[1:0];
  assign full_mask = tl_i.a_size == 2'd0 ? 4'b0001 << lo : tl_i.a_size == 2'd1 ? 4'b0011 << lo : 4'b1111;
  assign intg_bad = EnableCmdIntgChk &&
    (tl_i.a_user.cmd_intg != intg7(64'({tl_i.a_address, tl_i.a_opcode, tl_i.a_mask})) ||
     tl_i.a_user.data_intg != intg7(64'(tl_i.a_data)));
  assign req_bad = !(tl_i.a_opcode inside {PutFullData, PutPartialData, Get}) || tl_i.a_size == 2'd3 ||
    (tl_i.a_size == 2'd1 && lo[0]) || (tl_i.a_size == 2'd2 && lo != 2'd0) ||
    (tl_i.a_opcode == PutFullData && tl_i.a_mask != full_mask) ||
    (tl_i.a_address >> AW) != 32'd0 || intg_bad;
  assign timeout = TimeoutCycles != 0 && cnt_q == CW'(TimeoutCycles - 1);
  always_comb begin
    state_d = state_q;
    get_d = get_q;
    size_d = size_q;
    src_d = src_q;
    addr_d = addr_q;
    mask_d = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    cnt_d = cnt_q;
    intg_err_d = intg_err_q;
    if (state_q == Idle && tl_i.a_valid) begin
      // anything that is not a Put answers like a read (AccessAckData)
      get_d = !(tl_i.a_opcode inside {PutFullData, PutPartialData});
      size_d = tl_i.a_size;
      src_d = tl_i.a_source;
      addr_d = {tl_i.a_address[AW-1:2], 2'b00};
      mask_d = tl_i.a_mask;
      wdata_d = tl_i.a_data;
      err_d = req_bad;
      cnt_d = '0;
      intg_err_d = intg_err_q | intg_bad;
      state_d = req_bad ? Rsp : Access;
    end
    if (state_q == Access) begin
      if (reg_ready_i) begin
        rdata_d = reg_rdata_i;
        err_d = reg_err_i;
        state_d = Rsp;
      end else if (timeout) begin
        err_d = 1'b1;
        state_d = Rsp;
      end else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    if (state_q == Rsp && tl_i.d_ready) state_d = Idle;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      get_q <= 1'b0;
      size_q <= '0;
      src_q <= '0;
      addr_q <= '0;
      mask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      intg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      get_q <= get_d;
      size_q <= size_d;
      src_q <= src_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      intg_err_q <= intg_err_d;
    end
  end
  assign reg_re_o = state_q == Access && get_q;
  assign reg_we_o = state_q == Access && !get_q;
  assign reg_addr_o = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_be_o = mask_q;
  assign intg_err_o = intg_err_q;
  assign d_op = get_q ? AccessAckData : AccessAck;
  assign d_data = !get_q ? 32'h0 : err_q ? 32'hFFFF_FFFF : rdata_q;
  assign tl_o = '{
    d_valid:  state_q == Rsp,
    d_opcode: d_op,
    d_param:  3'd0,
    d_size:   size_q,
    d_source: src_q,
    d_sink:   1'b0,
    d_data:   d_data,
    d_user:   EnableRspIntgGen ? tl_d_user_t'{rsp_intg: intg7(64'({d_op, size_q, err_q})),
                                              data_intg: intg7(64'(d_data))} : tl_d_user_t'('0),
    d_error:  err_q,
    a_ready:  state_q == Idle
  };
endmodule
